// File: rtl/vector_mem_unit_if.sv
// vector_mem_unit_if: memory-stage pipe request/response plus 32-bit data RAM port
interface vector_mem_unit_if #(
    parameter int N = 32,
    parameter int V = 128
);
    logic         mem_read;
    logic         mem_write;
    logic         vector;
    logic [N-1:0] address;
    logic [V-1:0] wdata;
    logic [V-1:0] rdata;
    logic         stall;
    logic [N-1:0] ram_addr;
    logic [N-1:0] ram_wdata;
    logic         ram_we;
    logic [N-1:0] ram_rdata;
    modport slave (
        input  mem_read, mem_write, vector, address, wdata, ram_rdata,
        output rdata, stall, ram_addr, ram_wdata, ram_we
    );
    modport master (
        output mem_read, mem_write, vector, address, wdata, ram_rdata,
        input  rdata, stall, ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/vector_mem_unit.sv
// vector_mem_unit: splits scalar/vector loads and stores into 32-bit RAM beats, stalling the pipe until done
module vector_mem_unit #(
    parameter int N = 32,
    parameter int V = 128,
    parameter logic [N-1:0] ADDR_LIMIT = 'h3D08F
) (
    input logic clk,
    input logic rst_n,
    vector_mem_unit_if.slave bus
);
    localparam int L = V / N;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t       state_q, state_d;
    logic [2:0]   k_q, k_d, beats;
    logic         store_q, vec_q, req;
    logic [1:0]   cur_lane, prev_lane;
    logic [N-1:0] base_q, cur_addr, prev_addr, cap;
    logic [V-1:0] wdata_q, buf_q, buf_d, rdata_q, rdata_d;
    assign req       = bus.mem_read | bus.mem_write;
    assign beats     = vec_q ? 3'(L) : 3'd1;
    assign cur_lane  = k_q[1:0];
    assign prev_lane = cur_lane - 2'd1;
    assign cur_addr  = base_q + N'({cur_lane, 2'b00});
    assign prev_addr = base_q + N'({prev_lane, 2'b00});
    // synchronous RAM: data arriving now belongs to the previous beat's address
    assign cap       = prev_addr <= ADDR_LIMIT ? bus.ram_rdata : '0;
    assign bus.rdata = rdata_q;
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        buf_d         = buf_q;
        rdata_d       = rdata_q;
        bus.stall     = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        case (state_q)
            IDLE: begin
                bus.stall = req & rst_n;
                state_d   = req ? ISSUE : IDLE;
                k_d       = '0;
                buf_d     = req ? '0 : buf_q;
            end
            ISSUE: begin
                bus.stall     = 1'b1;
                bus.ram_addr  = cur_addr <= ADDR_LIMIT ? cur_addr : '0;
                bus.ram_we    = store_q && cur_addr <= ADDR_LIMIT;
                bus.ram_wdata = store_q ? wdata_q[N*cur_lane +: N] : '0;
                if (!store_q && k_q != 3'd0) buf_d[N*prev_lane +: N] = cap;
                k_d = k_q + 3'd1;
                if (k_q == beats - 3'd1) state_d = store_q ? DONE : DRAIN;
            end
            DRAIN: begin
                bus.stall = 1'b1;
                buf_d[N*prev_lane +: N] = cap;
                rdata_d   = buf_d;
                state_d   = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            store_q <= 1'b0;
            vec_q   <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            if (state_q == IDLE && req) begin
                store_q <= bus.mem_write;
                vec_q   <= bus.vector;
                base_q  <= bus.address & ~N'(3);
                wdata_q <= bus.wdata;
            end
        end
    end
endmodule

// File: doc/vector_mem_unit.md
Name: vector_mem_unit

Overview:
- Load/store unit in the memory stage, between the processor's Execution/Memory pipe outputs and the 32-bit-wide data RAM.
- Splits each 128-bit vector access into four sequential 32-bit word beats; a scalar access is one beat.
- Holds `stall` high to freeze the PC and all pipe registers until the access completes.
- Returns assembled load data to the Memory/Writeback pipe.

Parameters:
- N, 32, scalar word / RAM data width in bits.
- V, 128, vector width in bits. Lane count L = V/N = 4.
- ADDR_LIMIT, 32'h3D08F, highest valid byte address. Any beat address above it is out of range.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- mem_read  input  1  load request from the Memory stage (memtoreg).
- mem_write  input  1  store request from the Memory stage.
- vector  input  1  1 = vector access (L beats), 0 = scalar access (1 beat).
- address  input  N  byte address of lane 0.
- wdata  input  V  store data; lane k = wdata[N*k+N-1 : N*k].
- rdata  output  V  load result to the writeback pipe.
- stall  output  1  freeze request to the pipeline.
- ram_addr  output  N  RAM byte address for the current beat.
- ram_wdata  output  N  RAM write data for the current beat.
- ram_we  output  1  RAM write enable for the current beat.
- ram_rdata  input  N  RAM read data, synchronous: valid in the cycle after ram_addr is presented.

Behaviour:
- **Reset** (rst=0, any state, takes effect immediately): state=IDLE, beat counter=0, rdata=0, stall=0, ram_we=0, ram_addr=0, ram_wdata=0. An access interrupted by reset is abandoned; partial load data is discarded.
- **Request decode** (in IDLE only):
  - req = mem_read | mem_write.
  - If mem_write=1, the request is a store and mem_read is ignored (write priority).
  - Beats B = L if vector=1, else 1.
- **States:**
  - IDLE:
    - stall = req (combinational).
    - On req: latch op type, B, base = {address[N-1:2], 2'b00} (low 2 bits ignored) and wdata; clear the load buffer; go to ISSUE with beat k=0.
    - No req: stay in IDLE.
  - ISSUE:
    - stall=1.
    - Beat address = base + 4k, modulo 2^N.
    - ram_addr = beat address if it is <= ADDR_LIMIT, else 0.
    - Stores: ram_wdata = latched lane k; ram_we=1 only if in range.
    - Loads: ram_we=0; if k>=1, capture ram_rdata into lane k-1 of the buffer.
    - Increment k. Exit after beat B-1: stores go to DONE, loads go to DRAIN.
  - DRAIN (loads only): stall=1, ram_we=0; capture ram_rdata into lane B-1; go to DONE.
  - DONE:
    - stall=0, ram_we=0.
    - For a completed load, rdata = assembled buffer, stable for this whole cycle. The downstream pipes capture it at the closing edge.
    - Unconditional go to IDLE. The request still present this cycle is the completed one and is not re-issued.
- **Out-of-range beats:** write suppressed; the captured lane is forced to 0 regardless of ram_rdata.
- **Scalar load result:** the word in rdata[N-1:0]; upper lanes are 0.
- **rdata hold:** rdata holds its last load value across stores and idle cycles.
- **Stall length** (cycles with stall=1, counting the request cycle):
  - scalar store: 2
  - vector store: 5
  - scalar load: 3
  - vector load: 6
- **Outside ISSUE:** ram_we=0; ram_addr and ram_wdata are 0.
- **Back-to-back requests:** a request seen in the cycle after DONE starts a new access from IDLE with no gap penalty beyond the fixed stall lengths above.

Test Plan:
- Reset: assert rst=0 in the middle of a vector load (ISSUE, k=2) -> stall=0, ram_we=0, rdata=0 immediately; next request starts from IDLE.
- Vector store: address=0x100, wdata=0xDDDD_CCCC_BBBB_AAAA_... (lanes A,B,C,D) -> ram_we pulses at 0x100, 0x104, 0x108, 0x10C carrying lanes 0..3; stall high exactly 5 cycles.
- Vector load: RAM preloaded 0x200..0x20C = 1, 2, 3, 4 -> in DONE, rdata = {4,3,2,1} (lane 0 = 1); stall high exactly 6 cycles.
- Scalar load: address=0x207 (unaligned) with word 0x55 at 0x204 -> rdata = 0x...0055, upper 96 bits 0; stall 3 cycles. Scalar store of 0x99 at 0x300 -> one write, stall 2 cycles.
- Range boundary: vector store at 0x3D088 -> beats 0x3D088 and 0x3D08C written; 0x3D090 and 0x3D094 suppressed (ram_we=0, ram_addr=0). Vector load at the same address -> lanes 2 and 3 = 0.
- Priority and back-to-back: mem_read=mem_write=1 -> performed as a store, rdata unchanged. A vector load issued in the cycle after DONE completes with correct data and no re-issue of the prior store.
